uart_sort_ctrl: RTL
===================

UART_SORT_CTRL -- requirements
Module: uart_sort_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of every stream.
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum frame length in bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, allowed idle clocks between RX bytes inside a frame.
REQ-004 SHALL have ports clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rx_tdata  in  DATA_WIDTH, rx_tvalid  in  1, rx_tready  out  1: bytes from uart_rx.
REQ-006 SHALL have ports sort_tdata  out  DATA_WIDTH, sort_tvalid  out  1, sort_tready  in  1, sort_tlast  out  1, sort_abort  out  1: to the sorter.
REQ-007 SHALL have ports res_tdata  in  DATA_WIDTH, res_tvalid  in  1, res_tready  out  1, res_tlast  in  1: sorted data from the sorter.
REQ-008 SHALL have ports tx_tdata  out  DATA_WIDTH, tx_tvalid  out  1, tx_tready  in  1: bytes to uart_tx.
REQ-009 SHALL have ports busy  out  1, len_error  out  1, timeout_error  out  1, mismatch_error  out  1: status pulses and level.

Function
REQ-010 Transfers SHALL occur only when valid and ready are both high on a rising clk edge.
REQ-011 States SHALL be IDLE, LOAD, ECHO, DRAIN; busy SHALL be high in any state other than IDLE.
REQ-012 IDLE: rx_tready=1; an accepted byte SHALL be taken as frame length L and latched.
REQ-013 IDLE: L==0 or L>MAX_LEN SHALL pulse len_error for 1 cycle, discard the byte, and remain in IDLE.
REQ-014 IDLE: valid L SHALL load remaining-count cnt=L and move to LOAD on the next cycle.
REQ-015 LOAD: combinational pass-through, sort_tdata=rx_tdata, sort_tvalid=rx_tvalid, rx_tready=sort_tready, zero added latency.
REQ-016 LOAD: sort_tlast SHALL be high exactly when cnt==1; each transfer decrements cnt, and the cnt==1 transfer moves the FSM to ECHO.
REQ-017 LOAD: the idle counter resets on every RX transfer; reaching TIMEOUT_CYCLES SHALL pulse timeout_error and sort_abort for 1 cycle, drop the frame, and return to IDLE.
REQ-018 ECHO: tx_tdata=L and tx_tvalid=1 until accepted, then cnt=L and move to DRAIN; rx_tready=0.
REQ-019 DRAIN: pass-through, tx_tdata=res_tdata, tx_tvalid=res_tvalid, res_tready=tx_tready; each transfer decrements cnt.
REQ-020 DRAIN: a transfer with cnt==1 SHALL return the FSM to IDLE; if res_tlast!=(cnt==1) on any transfer, mismatch_error SHALL pulse for 1 cycle.
REQ-021 DRAIN: an early res_tlast SHALL still end the frame and return the FSM to IDLE.
REQ-022 Outside their pass-through states, sort_tvalid, sort_tlast, res_tready and tx_tvalid SHALL be 0, except ECHO tx_tvalid.
REQ-023 A timeout and a transfer in the same cycle SHALL resolve in favour of the transfer.
REQ-024 cnt width SHALL be $clog2(MAX_LEN+1); cnt SHALL never decrement below 0.

Reset
REQ-025 rst high SHALL immediately force IDLE, cnt=0, idle counter=0, L=0, all valids, tlast, abort, error pulses and busy to 0, and rx_tready to 1 once released.
REQ-026 Reset mid-frame SHALL discard all frame state with no sort_abort pulse; the sorter shares rst.

Structure
REQ-027 Package uart_sort_pkg SHALL hold the state enum, MAX_LEN_DEFAULT, and the length/count width constants.
REQ-028 Sub-module uart_timeout_cnt SHALL implement the clear/enable/expire idle counter; all other logic stays in uart_sort_ctrl.

Verification
REQ-029 Scenario 1: header 0x03, bytes 0x55,0xA3,0x11; sorter returns 0x11,0x55,0xA3 -> sort_tlast only on 0x11 in, TX emits 0x03,0x11,0x55,0xA3, and busy falls after the last byte.
REQ-030 Scenario 2: header 0x00, then header 0x41 with MAX_LEN=64 -> len_error pulses twice, no sort_tvalid, FSM stays IDLE.
REQ-031 Scenario 3: header 0x04 and 2 bytes, then silence for TIMEOUT_CYCLES=50 -> timeout_error and sort_abort 1-cycle pulses, busy=0, and the next frame works.
REQ-032 Scenario 4: tx_tready and sort_tready toggled randomly 50% during a 16-byte frame -> no byte lost or duplicated, and ordering is preserved.
REQ-033 Scenario 5: sorter asserts res_tlast on the 2nd of 3 results -> mismatch_error pulses and the FSM returns to IDLE.
REQ-034 Scenario 6: rst asserted asynchronously during DRAIN -> all outputs reach reset values before the next clk edge, and the next frame works.

Source files
------------

// File: rtl/uart_sort_pkg.sv
// Shared types and constants for the UART sort controller.
//   state_e         : controller FSM states
//   MAX_LEN_DEFAULT : default maximum frame length in bytes
//   LEN_W_DEFAULT   : default byte / length-header width
//   CNT_W_DEFAULT   : remaining-count width for the default MAX_LEN
//   cnt_width()     : remaining-count width for an arbitrary MAX_LEN
package uart_sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ECHO,
    DRAIN
  } state_e;

  localparam int unsigned MAX_LEN_DEFAULT = 64;
  localparam int unsigned LEN_W_DEFAULT   = 8;
  localparam int unsigned CNT_W_DEFAULT   = $clog2(MAX_LEN_DEFAULT + 1);

  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count (wins over en)
//   en       : count this cycle
//   expire   : combinational, high in the cycle that completes TIMEOUT_CYCLES
//              consecutive enabled, uncleared cycles
module uart_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_sort_ctrl.sv
// Frame controller between a UART and a byte sorter.
// A frame is a length byte L followed by L payload bytes. Payload is passed
// straight to the sorter; the reply is L echoed to TX followed by the sorted
// bytes returned by the sorter.
//   clk, rst                         : clock, asynchronous active-high reset
//   rx_tdata/tvalid/tready           : bytes from uart_rx
//   sort_tdata/tvalid/tready/tlast   : payload to the sorter
//   sort_abort                       : 1-cycle pulse, frame dropped on timeout
//   res_tdata/tvalid/tready/tlast    : sorted payload from the sorter
//   tx_tdata/tvalid/tready           : bytes to uart_tx
//   busy                             : level, frame in progress
//   len_error/timeout_error/mismatch_error : 1-cycle status pulses
module uart_sort_ctrl
  import uart_sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = LEN_W_DEFAULT,
  parameter int unsigned MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  output logic [DATA_WIDTH-1:0] sort_tdata,
  output logic                  sort_tvalid,
  input  logic                  sort_tready,
  output logic                  sort_tlast,
  output logic                  sort_abort,
  input  logic [DATA_WIDTH-1:0] res_tdata,
  input  logic                  res_tvalid,
  output logic                  res_tready,
  input  logic                  res_tlast,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic                  busy,
  output logic                  len_error,
  output logic                  timeout_error,
  output logic                  mismatch_error
);

  localparam int unsigned      CNT_W   = cnt_width(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic                  len_error_q, len_error_d;
  logic                  timeout_error_q, timeout_error_d;
  logic                  sort_abort_q, sort_abort_d;
  logic                  mismatch_error_q, mismatch_error_d;

  logic             rx_fire, tx_fire, res_fire;
  logic             cnt_is_one;
  logic [CNT_W-1:0] cnt_dec;
  logic             to_clr, to_en, to_expire;

  assign cnt_is_one = (cnt_q == CNT_ONE);
  // Saturating decrement: an early res_tlast or stray transfer never wraps.
  assign cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;

  assign rx_fire  = rx_tvalid & rx_tready;
  assign tx_fire  = tx_tvalid & tx_tready;
  assign res_fire = res_tvalid & res_tready;

  // Idle counter only runs in LOAD and restarts on every payload byte.
  assign to_en  = (state_q == LOAD);
  assign to_clr = (state_q != LOAD) | rx_fire;

  uart_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (to_clr),
    .en    (to_en),
    .expire(to_expire)
  );

  // Stream routing: zero-latency pass-through in LOAD and DRAIN.
  always_comb begin
    rx_tready   = 1'b0;
    sort_tdata  = '0;
    sort_tvalid = 1'b0;
    sort_tlast  = 1'b0;
    res_tready  = 1'b0;
    tx_tdata    = '0;
    tx_tvalid   = 1'b0;
    case (state_q)
      IDLE:  rx_tready = ~rst;
      LOAD: begin
        sort_tdata  = rx_tdata;
        sort_tvalid = rx_tvalid;
        sort_tlast  = cnt_is_one;
        rx_tready   = sort_tready;
      end
      ECHO: begin
        tx_tdata  = len_q;
        tx_tvalid = 1'b1;
      end
      DRAIN: begin
        tx_tdata   = res_tdata;
        tx_tvalid  = res_tvalid;
        res_tready = tx_tready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    len_error_d      = 1'b0;
    timeout_error_d  = 1'b0;
    sort_abort_d     = 1'b0;
    mismatch_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (rx_tdata == '0 || 32'(rx_tdata) > MAX_LEN) begin
            len_error_d = 1'b1;
          end else begin
            len_d   = rx_tdata;
            cnt_d   = CNT_W'(rx_tdata);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // A transfer in the expiry cycle wins: the counter's clr masks expire.
        if (rx_fire) begin
          cnt_d = cnt_dec;
          if (cnt_is_one) state_d = ECHO;
        end else if (to_expire) begin
          timeout_error_d = 1'b1;
          sort_abort_d    = 1'b1;
          cnt_d           = '0;
          len_d           = '0;
          state_d         = IDLE;
        end
      end
      ECHO: begin
        if (tx_fire) begin
          cnt_d   = CNT_W'(len_q);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_fire) begin
          cnt_d            = cnt_dec;
          mismatch_error_d = (res_tlast != cnt_is_one);
          if (cnt_is_one || res_tlast) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      len_q            <= '0;
      len_error_q      <= 1'b0;
      timeout_error_q  <= 1'b0;
      sort_abort_q     <= 1'b0;
      mismatch_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      len_q            <= len_d;
      len_error_q      <= len_error_d;
      timeout_error_q  <= timeout_error_d;
      sort_abort_q     <= sort_abort_d;
      mismatch_error_q <= mismatch_error_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign len_error      = len_error_q;
  assign timeout_error  = timeout_error_q;
  assign sort_abort     = sort_abort_q;
  assign mismatch_error = mismatch_error_q;

endmodule
